// File: rtl/rv32_mem_arbiter.sv
// Arbiter for one single-port memory shared by the RV32 fetch unit and the
// load/store path. Data requests win arbitration, but fetch is guaranteed a
// grant after STARVE_LIMIT consecutive data grants. Each access runs a
// req/ack handshake; if the memory stays silent for TIMEOUT cycles, the
// access is aborted and answered with an error.
module rv32_mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_f_req,
  input  logic [31:0] i_f_addr,
  output logic        o_f_gnt,
  output logic        o_f_valid,
  output logic [31:0] o_f_rdata,
  output logic        o_f_err,
  input  logic        i_d_req,
  input  logic        i_d_we,
  input  logic [3:0]  i_d_be,
  input  logic [31:0] i_d_addr,
  input  logic [31:0] i_d_wdata,
  output logic        o_d_gnt,
  output logic        o_d_valid,
  output logic [31:0] o_d_rdata,
  output logic        o_d_err,
  output logic        o_m_req,
  output logic        o_m_we,
  output logic [3:0]  o_m_be,
  output logic [31:0] o_m_addr,
  output logic [31:0] o_m_wdata,
  input  logic        i_m_ack,
  input  logic [31:0] i_m_rdata
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY_F = 2'd1;
  localparam logic [1:0] BUSY_D = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  // The wait counter only needs to reach TIMEOUT-1: the abort fires at the
  // end of the cycle in which it holds that value.
  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam int unsigned SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  logic [1:0]    state;
  logic [CW-1:0] wait_cnt;
  logic [SW-1:0] d_streak;

  logic arb_slot;
  logic grant_d;
  logic grant_f;
  logic busy;
  logic ack_hit;
  logic tmo_hit;

  // Arbitration and completion decode for the current cycle.
  always_comb begin
    arb_slot = (state == IDLE) || (state == RESP);
    grant_d  = arb_slot && i_d_req && !(i_f_req && (d_streak == SW'(STARVE_LIMIT)));
    grant_f  = arb_slot && i_f_req && !grant_d;
    busy     = (state == BUSY_F) || (state == BUSY_D);
    // Ack beats timeout when both land in the same cycle.
    ack_hit  = busy && i_m_ack;
    tmo_hit  = busy && !i_m_ack && (wait_cnt == CW'(TIMEOUT - 1));
  end

  // Sequencer state, memory-side request registers and requester responses.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      d_streak  <= '0;
      o_f_gnt   <= 1'b0;
      o_f_valid <= 1'b0;
      o_f_rdata <= '0;
      o_f_err   <= 1'b0;
      o_d_gnt   <= 1'b0;
      o_d_valid <= 1'b0;
      o_d_rdata <= '0;
      o_d_err   <= 1'b0;
      o_m_req   <= 1'b0;
      o_m_we    <= 1'b0;
      o_m_be    <= '0;
      o_m_addr  <= '0;
      o_m_wdata <= '0;
    end else begin
      o_f_gnt   <= 1'b0;
      o_d_gnt   <= 1'b0;
      o_f_valid <= 1'b0;
      o_d_valid <= 1'b0;

      // Streak counts data grants won while fetch was waiting.
      if (!i_f_req || grant_f) begin
        d_streak <= '0;
      end else if (grant_d) begin
        d_streak <= d_streak + SW'(1);
      end

      case (state)
        IDLE, RESP: begin
          if (grant_d) begin
            state     <= BUSY_D;
            wait_cnt  <= '0;
            o_d_gnt   <= 1'b1;
            o_m_req   <= 1'b1;
            o_m_we    <= i_d_we;
            o_m_be    <= i_d_be;
            o_m_addr  <= i_d_addr;
            o_m_wdata <= i_d_wdata;
          end else if (grant_f) begin
            state     <= BUSY_F;
            wait_cnt  <= '0;
            o_f_gnt   <= 1'b1;
            o_m_req   <= 1'b1;
            o_m_we    <= 1'b0;
            o_m_be    <= 4'hF;
            o_m_addr  <= i_f_addr;
            o_m_wdata <= '0;
          end else begin
            state <= IDLE;
          end
        end
        BUSY_F, BUSY_D: begin
          wait_cnt <= wait_cnt + CW'(1);
          if (ack_hit || tmo_hit) begin
            state   <= RESP;
            o_m_req <= 1'b0;
            if (state == BUSY_F) begin
              o_f_valid <= 1'b1;
              o_f_err   <= tmo_hit;
              o_f_rdata <= ack_hit ? i_m_rdata : 32'h0;
            end else begin
              o_d_valid <= 1'b1;
              o_d_err   <= tmo_hit;
              // Stores carry no read data back.
              o_d_rdata <= (ack_hit && !o_m_we) ? i_m_rdata : 32'h0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
